// File: rtl/counter_timer_pkg.sv
// Shared types, defaults and helpers for the counter/timer arbiter.
package counter_timer_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_CW     = 8;
    // Flattened length bus width seen by the slice helper (8 requesters x 32 bits max).
    localparam int LEN_FLAT_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Extract requester idx's cw-bit length from the flattened length bus.
    function automatic logic [31:0] len_slice(input logic [LEN_FLAT_W-1:0] flat,
                                              input int unsigned idx,
                                              input int unsigned cw);
        logic [LEN_FLAT_W-1:0] sh;
        logic [63:0]           mask;
        sh   = flat >> (idx * cw);
        mask = (64'd1 << cw) - 64'd1;
        return sh[31:0] & mask[31:0];
    endfunction

endpackage

// File: rtl/counter_timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arbiter
    import counter_timer_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_oh_o,
    output logic [IW-1:0]   pick_idx_o,
    output logic            pick_vld_o
);

    localparam logic [NREQ-1:0] ONE_OH = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IW-1:0] cand_s;

    // Scan NREQ candidates starting at the pointer and keep the first requesting one.
    always_comb begin
        pick_oh_o  = '0;
        pick_idx_o = '0;
        pick_vld_o = 1'b0;
        cand_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % NREQ);
            if (!pick_vld_o && req_i[cand_s]) begin
                pick_vld_o = 1'b1;
                pick_idx_o = cand_s;
            end else begin
                pick_vld_o = pick_vld_o;
            end
        end
        if (pick_vld_o) begin
            pick_oh_o = ONE_OH << pick_idx_o;
        end else begin
            pick_oh_o = '0;
        end
    end

endmodule

// File: rtl/counter_timer_arbiter.sv
// Shares one external up_counter between NREQ requesters, granting timed intervals round-robin.
module counter_timer_arbiter
    import counter_timer_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               cnt_en,
    output logic               cnt_rst,
    input  logic [CW-1:0]      cnt_val
);

    localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NREQ - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     len_lat_q, len_lat_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;

    logic [NREQ-1:0]   pick_oh_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_vld_s;
    logic [IW-1:0]     idx_next_s;
    logic [LEN_FLAT_W-1:0] len_flat_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .pick_oh_o  (pick_oh_s),
        .pick_idx_o (pick_idx_s),
        .pick_vld_o (pick_vld_s)
    );

    assign len_flat_s = LEN_FLAT_W'(len);
    assign idx_next_s = (idx_q == IDX_MAX) ? '0 : (idx_q + IDX_ONE);

    // Counter control and status are decoded only from registered state so they cannot glitch on req.
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);
    assign cnt_rst = (state_q != ST_RUN);
    assign cnt_en  = (state_q == ST_RUN) && (cnt_val != len_lat_q);

    // Next-state logic: grant in IDLE, watch for abort or match in RUN, single done cycle in DONE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        len_lat_d = len_lat_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_d   = ST_RUN;
                    idx_d     = pick_idx_s;
                    len_lat_d = CW'(len_slice(len_flat_s, 32'(pick_idx_s), 32'(CW)));
                    gnt_d     = pick_oh_s;
                end else begin
                    gnt_d     = '0;
                end
            end
            ST_RUN: begin
                // Abort wins over a simultaneous match: the requester has gone away.
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = idx_next_s;
                end else if (cnt_val == len_lat_q) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = idx_next_s;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and latch registers with asynchronous reset to an idle, cleared-counter condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            len_lat_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            len_lat_q <= len_lat_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Self-checking bench for counter_timer_arbiter with a behavioural up_counter beside it.
module tb_counter_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] len_bus = 32'd0;
    logic [3:0]  gnt, done;
    logic        busy, cnt_en, cnt_rst;
    logic [7:0]  cnt_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0] oh;
        int         l;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] req;
        logic [7:0] len;
        logic [3:0] exp_gnt;
    } vec_t;
    vec_t vecs[5];

    counter_timer_arbiter #(.NREQ(4), .CW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len_bus),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_en  (cnt_en),
        .cnt_rst (cnt_rst),
        .cnt_val (cnt_val)
    );

    always #5 clk = ~clk;

    // Edge counter: sampled at a negedge it equals the index of the edge that started the cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Shared up_counter model: synchronous clear beats increment, otherwise hold.
    always @(posedge clk) begin
        if (cnt_rst) cnt_val <= 8'd0;
        else if (cnt_en) cnt_val <= cnt_val + 8'd1;
        else cnt_val <= cnt_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_len(input int i, input logic [7:0] v);
        len_bus[i*8 +: 8] = v;
    endtask

    // Serve the next expected interval from the scoreboard, checking grant, timing and done.
    task automatic serve(input bit drop, output int e);
        exp_t ex;
        bit   seen;
        bit   dseen;
        int   en_n;
        int   gnt_n;
        e = cyc;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        ex   = sb.pop_front();
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (gnt != 4'd0) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            chk("gnt_timeout", 32'(gnt), 32'(ex.oh));
            return;
        end
        e = cyc;
        chk("gnt", 32'(gnt), 32'(ex.oh));
        chk("busy_run", 32'(busy), 32'd1);
        chk("cnt_entry", 32'(cnt_val), 32'd0);
        en_n  = 0;
        gnt_n = 0;
        dseen = 1'b0;
        for (int k = 0; k < ex.l + 8 && !dseen; k++) begin
            if (done != 4'd0) dseen = 1'b1;
            else begin
                if (cnt_en) en_n++;
                if (gnt != 4'd0) gnt_n++;
                @(negedge clk);
            end
        end
        if (!dseen) begin
            chk("done_timeout", 32'(done), 32'(ex.oh));
            return;
        end
        chk("done_vec", 32'(done), 32'(ex.oh));
        chk("done_cyc", 32'(cyc), 32'(e + ex.l + 1));
        chk("en_cycles", 32'(en_n), 32'(ex.l));
        chk("gnt_cycles", 32'(gnt_n), 32'(ex.l + 1));
        chk("cnt_final", 32'(cnt_val), 32'(ex.l));
        chk("rst_in_done", 32'(cnt_rst), 32'd1);
        chk("gnt_in_done", 32'(gnt), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        if (drop) req = req & ~ex.oh;
        @(negedge clk);
        chk("done_pulse_len", 32'(done), 32'd0);
    endtask

    initial begin
        int  e;
        int  prev_e;
        bit  seen;
        bit  bad_done;

        // Single-requester vectors; the last one serves port 3 so the pointer wraps back to 0.
        vecs[0] = '{req: 4'b0001, len: 8'd5,   exp_gnt: 4'b0001};
        vecs[1] = '{req: 4'b0010, len: 8'd0,   exp_gnt: 4'b0010};
        vecs[2] = '{req: 4'b0100, len: 8'd1,   exp_gnt: 4'b0100};
        vecs[3] = '{req: 4'b0001, len: 8'd2,   exp_gnt: 4'b0001};
        vecs[4] = '{req: 4'b1000, len: 8'd255, exp_gnt: 4'b1000};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_cnt_val", 32'(cnt_val), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Table-driven single intervals.
        for (int v = 0; v < 5; v++) begin
            len_bus = 32'd0;
            for (int i = 0; i < 4; i++) set_len(i, vecs[v].len);
            req = vecs[v].req;
            sb.push_back('{oh: vecs[v].exp_gnt, l: int'(vecs[v].len)});
            serve(1'b1, e);
        end

        // All four request together with len 2: strict rotation, grants 5 cycles apart.
        for (int i = 0; i < 4; i++) set_len(i, 8'd2);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) sb.push_back('{oh: 4'(4'b0001 << i), l: 2});
        prev_e = 0;
        for (int i = 0; i < 4; i++) begin
            serve(1'b1, e);
            if (i > 0) chk("grant_spacing", 32'(e - prev_e), 32'd5);
            prev_e = e;
        end

        // Port 0 held continuously; port 2 raised during its run must be served before port 0 again.
        set_len(0, 8'd4);
        set_len(2, 8'd4);
        req = 4'b0001;
        sb.push_back('{oh: 4'b0001, l: 4});
        sb.push_back('{oh: 4'b0100, l: 4});
        sb.push_back('{oh: 4'b0001, l: 4});
        @(negedge clk);
        req[2] = 1'b1;
        serve(1'b0, e);
        serve(1'b1, e);
        serve(1'b1, e);

        // Abort: port 1 drops at count 3; no done, pointer moves past port 1.
        set_len(1, 8'd10);
        set_len(2, 8'd1);
        req = 4'b0010;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (gnt == 4'b0010 && cnt_val == 8'd3) seen = 1'b1;
        end
        chk("abort_reach_3", 32'(seen), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt_rst", 32'(cnt_rst), 32'd1);
        bad_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done != 4'd0) bad_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(bad_done), 32'd0);
        set_len(1, 8'd1);
        req = 4'b0110;
        sb.push_back('{oh: 4'b0100, l: 1});
        sb.push_back('{oh: 4'b0010, l: 1});
        serve(1'b1, e);
        serve(1'b1, e);

        // Async reset mid-run, then first grant from pointer 0 goes to the lowest set bit.
        set_len(0, 8'd20);
        req = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (gnt == 4'b0001 && cnt_val == 8'd3) seen = 1'b1;
        end
        chk("pre_rst_run", 32'(seen), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("arst_cnt_en", 32'(cnt_en), 32'd0);
        set_len(1, 8'd2);
        set_len(3, 8'd2);
        req = 4'b1010;
        @(negedge clk);
        chk("arst_cnt_clear", 32'(cnt_val), 32'd0);
        chk("arst_hold_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        sb.push_back('{oh: 4'b0010, l: 2});
        sb.push_back('{oh: 4'b1000, l: 2});
        serve(1'b1, e);
        serve(1'b1, e);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_timer_arbiter.md
Name: counter_timer_arbiter

Overview:
Shares one up_counter instance between NREQ requesters. Each requester asks for a timed interval of len[i] counted cycles. The block grants round-robin, drives the counter's en/rst, compares the returned count against the latched length, and pulses done[i] when the interval completes. It sits beside the up_counter; requesters never touch the counter directly.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 8, counter width; must equal the width of the shared up_counter

Ports:
clk  in  1  rising-edge clock shared with the up_counter
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level; held until done or deliberately dropped (abort)
len  in  NREQ*CW  packed lengths; requester i uses bits [i*CW +: CW]
gnt  out  NREQ  one-hot grant; high for the whole RUN state of the granted requester
done  out  NREQ  one-cycle completion pulse to the served requester
busy  out  1  high in RUN and DONE
cnt_en  out  1  drives the up_counter en input
cnt_rst  out  1  drives the up_counter rst input (synchronous clear in the counter)
cnt_val  in  CW  the up_counter count output

Behaviour:
- Counter contract: on each clk edge, the up_counter loads 0 if rst=1, else increments if en=1, else holds.
- FSM states: IDLE, RUN, DONE, held in a registered state.
- Reset (async) forces:
  - state=IDLE, gnt=0, done=0, busy=0, rr pointer=0, len_lat=0, idx=0.
  - cnt_rst=1 and cnt_en=0 immediately.
  - The counter therefore clears on every edge while rst is high.
- IDLE:
  - cnt_rst=1, cnt_en=0, gnt=0, busy=0.
  - If any req bit is set, pick the first set bit searching upward from the pointer, modulo NREQ.
  - On that edge: latch idx, latch len_lat=len[idx], set gnt=onehot(idx), go to RUN.
  - No request: stay in IDLE.
- RUN:
  - cnt_rst=0, busy=1.
  - cnt_en = (cnt_val != len_lat), combinational from state, cnt_val and len_lat.
  - The counter is 0 on entry because it was held cleared in IDLE.
  - If cnt_val == len_lat: next state DONE, gnt cleared on that edge.
  - If req[idx]==0 (abort): next state IDLE, no done pulse, gnt cleared, pointer=(idx+1) mod NREQ. Abort takes priority over the match in the same cycle.
  - Changes to len or other req bits during RUN are ignored.
- DONE:
  - done[idx]=1 for exactly one cycle, gnt=0, busy=1, cnt_rst=1, cnt_en=0.
  - Pointer=(idx+1) mod NREQ; next state IDLE.
- Timing: if gnt rises on edge E, RUN lasts len_lat+1 cycles with exactly len_lat cnt_en-high cycles.
  - done is high in the cycle starting at edge E+len_lat+1.
  - Next grant is no earlier than edge E+len_lat+3.
- Width and wrap:
  - len_lat ≤ 2^CW−1, so the match always occurs before the counter can wrap. No wrap handling is required.
  - len=0 is legal: RUN lasts 1 cycle with cnt_en=0.
- gnt, done and busy are registered (or decoded purely from registered state); they are glitch-free.
- Fairness: a continuously requesting port waits at most NREQ−1 other intervals.

Decomposition:
- Package counter_timer_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default CW/NREQ constants;
  - the len-slice helper function.
- One sub-module, rr_arbiter (req, pointer → one-hot pick plus index), purely combinational. The top holds the FSM, latches and pointer register.

Test Plan:
1. req=0001, len0=5 → gnt=0001 from edge E; cnt_en high 5 cycles, cnt_val steps 0..5; done=0001 pulse at E+6; cnt_rst high again after done.
2. req=1111 simultaneously, all len=2, held until own done → grants in order 0001,0010,0100,1000. Each gnt lasts 3 cycles; done pulses are spaced 5 cycles apart.
3. req0 held permanently plus req2 raised during req0's RUN → after done[0], gnt=0100 before req0 is granted again.
4. req=0010, len1=0 → gnt one cycle, cnt_en never high, done[1] at E+1. Separately, len3=255 → cnt_val reaches 255 without wrap, done[3] at E+256.
5. req1 dropped while cnt_val=3 (len1=10) → next edge IDLE, gnt=0, done never pulses; pointer advances so req2 wins over a re-asserted req1.
6. Async rst asserted mid-RUN, between edges → gnt, done and busy go to 0 and cnt_rst to 1 immediately. After release, the counter is cleared and the first grant goes to the lowest set req bit (pointer=0).
